// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with valid/ready handshakes.
// Logic/arith ops finish in one cycle; shifts and multiply iterate one bit per cycle.
// Ports: clk, reset (async, active-high); in_valid/in_ready/Operation/a/b request side;
//        out_valid/out_ready/result/zero/illegal response side; busy while not IDLE.
module alu_seq_exec #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011,
                           OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
                           OP_MUL = 4'b1000, OP_SRA = 4'b1101;
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_TWO = (SHW+1)'(2);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic             zero_q, zero_d, illegal_q, illegal_d;
    logic             load, load_ill;
    logic [WIDTH-1:0] load_val, sum, first_shift;
    logic [SHW-1:0]   shamt;

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
        shift1 = op == OP_SLL ? {v[WIDTH-2:0], 1'b0} :
                 op == OP_SRA ? {v[WIDTH-1], v[WIDTH-1:1]} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign shamt       = b[SHW-1:0];
    assign sum         = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign first_shift = shift1(Operation, a);

    // The accept edge performs the first shift, so a shift of N finishes N edges after accept.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        load      = 1'b0;
        load_ill  = 1'b0;
        load_val  = '0;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = Operation;
                case (Operation)
                    OP_AND: begin load = 1'b1; load_val = a & b; end
                    OP_OR:  begin load = 1'b1; load_val = a | b; end
                    OP_ADD: begin load = 1'b1; load_val = a + b; end
                    OP_SUB: begin load = 1'b1; load_val = a - b; end
                    OP_XOR: begin load = 1'b1; load_val = a ^ b; end
                    OP_SLT: begin load = 1'b1; load_val = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)}; end
                    OP_SLL, OP_SRL, OP_SRA: begin
                        acc_d = first_shift;
                        cnt_d = {1'b0, shamt};
                        if (shamt == '0) begin
                            load     = 1'b1;
                            load_val = a;
                        end else if (shamt == SHW'(1)) begin
                            load     = 1'b1;
                            load_val = first_shift;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                    OP_MUL: begin
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = CNT_MUL;
                        state_d  = EXEC;
                    end
                    default: begin load = 1'b1; load_ill = 1'b1; end
                endcase
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    acc_d    = sum;
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    load     = cnt_q == CNT_ONE;
                    load_val = sum;
                end else begin
                    acc_d    = shift1(op_q, acc_q);
                    load     = cnt_q == CNT_TWO;
                    load_val = shift1(op_q, acc_q);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d   = DONE;
            result_d  = load_val;
            zero_d    = load_val == '0;
            illegal_d = load_ill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: table-driven scoreboard bench for alu_seq_exec.
module tb_alu_seq_exec;
    localparam int W = 64;
    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]   Operation = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, zero, illegal, busy;
    logic [W-1:0] result;
    int           n_cmp = 0, n_err = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         z, ill;
        int           lat;
    } vec_t;
    typedef struct {
        logic [W-1:0] res;
        logic         z, ill;
        int           lat;
    } exp_t;
    exp_t sb[$];
    vec_t vecs[18];

    alu_seq_exec #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int bp, input bit poke);
        exp_t         e;
        int           lat;
        logic [W-1:0] held;
        @(negedge clk);
        chk("in_ready_before", in_ready, 1);
        in_valid  = 1'b1;
        Operation = v.op;
        a         = v.a;
        b         = v.b;
        out_ready = bp == 0;
        sb.push_back('{v.res, v.z, v.ill, v.lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        lat      = 1;
        while (!out_valid && lat < 200) begin
            if (poke) begin
                chk("in_ready_exec", in_ready, 0);
                in_valid  = 1'b1;
                Operation = 4'b0000;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("out_valid", out_valid, 1);
        chk("latency", W'(lat), W'(e.lat));
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("illegal", illegal, e.ill);
        held = result;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, held);
            chk("bp_flags", {zero, illegal}, {e.z, e.ill});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        vecs[0]  = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'b0110, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'b0111, '1, 64'd1, 64'd1, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'b0111, 64'd1, '1, 64'd0, 1'b1, 1'b0, 1};
        vecs[4]  = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'b0011, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'b0010, '1, 64'd1, 64'd0, 1'b1, 1'b0, 1};
        vecs[8]  = '{4'b0100, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 63};
        vecs[9]  = '{4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 4};
        vecs[10] = '{4'b0101, 64'h123, 64'd0, 64'h123, 1'b0, 1'b0, 1};
        vecs[11] = '{4'b0101, 64'h80, 64'hFF00_0000_0000_0041, 64'h40, 1'b0, 1'b0, 1};
        vecs[12] = '{4'b0101, 64'h8000_0000_0000_0000, 64'd2, 64'h2000_0000_0000_0000, 1'b0, 1'b0, 2};
        vecs[13] = '{4'b1000, '1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 65};
        vecs[14] = '{4'b1000, 64'd12345, 64'd678, 64'd8369910, 1'b0, 1'b0, 65};
        vecs[15] = '{4'b1001, 64'd9, 64'd9, 64'd0, 1'b1, 1'b1, 1};
        vecs[16] = '{4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1};
        vecs[17] = '{4'b0101, 64'hF0, 64'd3, 64'h1E, 1'b0, 1'b0, 3};

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, illegal, busy}, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        foreach (vecs[i]) run_op(vecs[i], 0, 1'b0);

        run_op('{4'b1000, '1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 65}, 0, 1'b1);
        run_op('{4'b1111, 64'd1, 64'd2, 64'd0, 1'b1, 1'b1, 1}, 10, 1'b0);

        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 4'b1000;
        a         = 64'd77;
        b         = 64'd99;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("mul_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {zero, illegal, busy}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        run_op('{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1}, 0, 1'b0);
        chk("sb_empty", W'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that takes the 4-bit Operation code from the ALU control decoder, together with two register/immediate operands.
- Returns the result and the zero flag to the branch/writeback logic.
- Uses a valid/ready handshake on both sides.
- Logic ops finish in one cycle; shifts and multiply are iterative (1 bit per cycle), so the datapath stalls through the handshake.

Parameters:
- WIDTH, 64, operand/result width in bits (power of two, at least 8).
- SHW, $clog2(WIDTH), shift-amount width, derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- Operation  input  4  ALU operation code from ALU control.
- a  input  WIDTH  operand A (rs1).
- b  input  WIDTH  operand B (rs2 or immediate).
- out_valid  output  1  result/zero/illegal valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- illegal  output  1  registered; Operation code was unsupported.
- busy  output  1  high in EXEC or DONE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, result=0, zero=0, illegal=0, out_valid=0, counter=0.
  - in_ready is high after reset deasserts.
- Operation encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (produced by ALU control).
  - Extended codes: 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA, 0111 SLT (signed), 1000 MUL (low WIDTH bits of a*b).
  - Any other code is illegal.
- Accept: transfer occurs when in_valid && in_ready. Operation, a and b are latched into internal registers. Inputs are ignored at all other times.
- States:
  - IDLE: in_ready=1. On accept:
    - single-cycle op or illegal code -> compute, load result, go DONE.
    - shift op -> load acc=a, cnt=b[SHW-1:0], go EXEC. If cnt==0, go DONE with result=a.
    - MUL -> load acc=0, mcand=a, mplier=b, cnt=WIDTH, go EXEC.
  - EXEC:
    - Shift: each cycle shift acc by 1 (SLL zero-fill left, SRL zero-fill right, SRA replicate MSB) and decrement cnt. When cnt reaches 1 -> write final value to result and go DONE.
    - MUL: each cycle, if mplier[0], acc += mcand (mod 2^WIDTH); then mcand <<= 1, mplier >>= 1, cnt--. After the WIDTH-th iteration -> result=acc, go DONE.
  - DONE:
    - out_valid=1; result, zero and illegal are stable.
    - On out_ready -> go IDLE with out_valid=0 on the next cycle.
    - A new accept cannot occur in the same cycle as out_ready (in_ready=0 in DONE).
- Latency (accept edge to out_valid high):
  - AND/OR/ADD/SUB/XOR/SLT/illegal: 1 cycle.
  - Shift: max(1, shamt) cycles.
  - MUL: WIDTH+1 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT: result = {WIDTH-1 zeros, ($signed(a) < $signed(b))}.
  - Shift amount uses b[SHW-1:0] only; upper bits of b are ignored.
- Illegal code: result=0, zero=1, illegal=1.
- Flags: zero and illegal are registered together with result. illegal clears when the next result is loaded.
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Reset mid-operation (EXEC or DONE): the operation is aborted, all outputs return to reset values immediately, and no partial result is emitted.
- Outputs never change while out_valid=1.

Test Plan:
1. Reset then ADD with a=5, b=7, out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0, illegal=0, then in_ready=1.
2. SUB with a=b=0x1234 -> result=0, zero=1. Next, SLT with a=-1, b=1 -> result=1.
3. SLL with a=1, b=63 -> out_valid after 63 cycles, result=0x8000_0000_0000_0000. SRA with a=0x8000_0000_0000_0000, b=4 -> result=0xF800_0000_0000_0000. SRL with b=0 -> result=a after 1 cycle.
4. MUL with a=0xFFFF_FFFF_FFFF_FFFF, b=3 -> out_valid after 65 cycles, result=0xFFFF_FFFF_FFFF_FFFD. During EXEC, in_valid pulses are ignored and in_ready=0.
5. Operation=1111 -> illegal=1, result=0, zero=1. Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
6. Assert reset during MUL EXEC at cycle 20 -> out_valid=0, result=0 immediately. After release, an AND with a=0xF0, b=0x3C returns 0x30.
